// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, frame limits and format helpers
package uart_pkg;

  localparam int         BIT_TICKS = 16;
  localparam logic [3:0] MIN_BITS  = 4'd5;
  localparam logic [3:0] MAX_BITS  = 4'd8;

  // Numeric values are shared with the receive stage.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    GAP    = 3'd5
  } uart_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  function automatic logic [3:0] clamp_bits(input logic [3:0] n);
    if (n < MIN_BITS) return MIN_BITS;
    if (n > MAX_BITS) return MAX_BITS;
    return n;
  endfunction

  function automatic logic [7:0] data_mask(input logic [3:0] n);
    return 8'hFF >> (MAX_BITS - n);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - per-bit tick counter with a strobe on the last tick of each bit
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  output logic [3:0] o_tick,
  output logic       o_bit_end
);

  logic [3:0] tick_q, tick_d;

  assign o_tick    = tick_q;
  assign o_bit_end = (tick_q == 4'(BIT_TICKS - 1));

  always_comb begin
    tick_d = tick_q + 4'd1;
    if (i_clr || o_bit_end) tick_d = 4'd0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) tick_q <= 4'd0;
    else       tick_q <= tick_d;
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART frame transmitter on the x16 clock, format latched per byte
module uart_tx
  import uart_pkg::*;
#(
  parameter int GAP_BITS = 1
) (
  input  logic       i_clkx16,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  output logic       o_ready,
  input  logic       i_exist_oddcheck,
  input  logic       i_exist_evencheck,
  input  logic       i_exist_stop,
  input  logic [3:0] i_bitnum,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [1:0] GAP_LAST = 2'(GAP_BITS - 1);

  uart_state_e state_q, state_d;
  parity_e     par_q, par_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  nbits_q, nbits_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  gap_q, gap_d;
  logic        par_bit_q, par_bit_d;
  logic        stop_q, stop_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [3:0]  tick;
  logic        bit_end;
  logic [3:0]  nbits_in;
  logic [7:0]  masked_in;

  uart_bit_timer u_timer (
    .i_clk     (i_clkx16),
    .i_rst     (i_rst),
    .i_clr     (state_q == IDLE),
    .o_tick    (tick),
    .o_bit_end (bit_end)
  );

  assign o_ready = (state_q == IDLE) & ~i_rst;
  assign o_tx    = tx_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

  always_comb begin
    nbits_in  = clamp_bits(i_bitnum);
    masked_in = i_data & data_mask(nbits_in);
    state_d   = state_q;
    par_d     = par_q;
    data_d    = data_q;
    nbits_d   = nbits_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    par_bit_d = par_bit_q;
    stop_d    = stop_q;

    case (state_q)
      IDLE: begin
        if (i_data_valid) begin
          state_d = START;
          data_d  = masked_in;
          nbits_d = nbits_in;
          stop_d  = i_exist_stop;
          // Odd wins when both parity flags are set.
          if (i_exist_oddcheck) begin
            par_d     = PAR_ODD;
            par_bit_d = ~^masked_in;
          end else if (i_exist_evencheck) begin
            par_d     = PAR_EVEN;
            par_bit_d = ^masked_in;
          end else begin
            par_d     = PAR_NONE;
            par_bit_d = 1'b0;
          end
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if ({1'b0, bit_q} == nbits_q - 4'd1) begin
            gap_d = 2'd0;
            if (par_q != PAR_NONE) state_d = PARITY;
            else if (stop_q)       state_d = STOP;
            else                   state_d = GAP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          gap_d   = 2'd0;
          state_d = stop_q ? STOP : GAP;
        end
      end
      STOP: begin
        if (bit_end) begin
          gap_d   = 2'd0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (bit_end) begin
          if (gap_q == GAP_LAST) state_d = IDLE;
          else                   gap_d   = gap_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is derived from the next state so o_tx stays a plain flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_d];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_q == GAP) && (tick == 4'(BIT_TICKS - 2)) && (gap_q == GAP_LAST);
  end

  always_ff @(posedge i_clkx16) begin
    if (i_rst) begin
      state_q   <= IDLE;
      par_q     <= PAR_NONE;
      data_q    <= 8'd0;
      nbits_q   <= MAX_BITS;
      bit_q     <= 3'd0;
      gap_q     <= 2'd0;
      par_bit_q <= 1'b0;
      stop_q    <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      par_q     <= par_d;
      data_q    <= data_d;
      nbits_q   <= nbits_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      par_bit_q <= par_bit_d;
      stop_q    <= stop_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized frame checks of uart_tx against a slot-level line model
module tb_uart_tx;

  localparam int GAP   = 1;
  localparam int TICKS = 16;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_data = 8'd0;
  logic       i_data_valid = 1'b0;
  logic       i_exist_oddcheck = 1'b0;
  logic       i_exist_evencheck = 1'b0;
  logic       i_exist_stop = 1'b0;
  logic [3:0] i_bitnum = 4'd8;
  logic       o_ready, o_tx, o_busy, o_done;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_slots[$];
  bit prev_hold = 1'b0;

  always #5 clk = ~clk;

  uart_tx #(.GAP_BITS(GAP)) dut (
    .i_clkx16          (clk),
    .i_rst             (i_rst),
    .i_data            (i_data),
    .i_data_valid      (i_data_valid),
    .o_ready           (o_ready),
    .i_exist_oddcheck  (i_exist_oddcheck),
    .i_exist_evencheck (i_exist_evencheck),
    .i_exist_stop      (i_exist_stop),
    .i_bitnum          (i_bitnum),
    .o_tx              (o_tx),
    .o_busy            (o_busy),
    .o_done            (o_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line level per bit-time: start, n data bits LSB first, parity, stop, idle gap.
  function automatic void build_frame(input logic [7:0] d, input int bn,
                                      input bit odd, input bit even, input bit stop);
    int n;
    int ones;
    n = (bn < 5) ? 5 : (bn > 8) ? 8 : bn;
    ones = 0;
    exp_slots.delete();
    exp_slots.push_back(1'b0);
    for (int k = 0; k < n; k++) begin
      exp_slots.push_back(d[k]);
      ones += int'(d[k]);
    end
    if (odd)       exp_slots.push_back((ones % 2) == 0);
    else if (even) exp_slots.push_back((ones % 2) == 1);
    if (stop) exp_slots.push_back(1'b1);
    for (int g = 0; g < GAP; g++) exp_slots.push_back(1'b1);
  endfunction

  task automatic send(input logic [7:0] d, input logic [3:0] bn, input bit odd,
                      input bit even, input bit stop, input bit hold, input int abort_at);
    int waited;
    int len;
    i_data            = d;
    i_bitnum          = bn;
    i_exist_oddcheck  = odd;
    i_exist_evencheck = even;
    i_exist_stop      = stop;
    i_data_valid      = 1'b1;
    waited = 0;
    while (!o_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_timeout", (waited >= 400), 0);
    if (waited >= 400) return;
    if (prev_hold) chk("b2b_spacing", waited, 0);
    prev_hold = hold;
    build_frame(d, int'(bn), odd, even, stop);
    len = TICKS * exp_slots.size();
    @(posedge clk);
    for (int c = 1; c <= len + 1; c++) begin
      @(negedge clk);
      if (abort_at != 0 && c == abort_at) begin
        i_rst = 1'b1;
        i_data_valid = 1'b0;
        @(negedge clk);
        i_rst = 1'b0;
        #1;
        chk("abort_tx", o_tx, 1);
        chk("abort_ready", o_ready, 1);
        chk("abort_busy", o_busy, 0);
        chk("abort_done", o_done, 0);
        prev_hold = 1'b0;
        return;
      end
      if (c <= len) begin
        chk("tx", o_tx, exp_slots[(c - 1) / TICKS]);
        chk("busy", o_busy, 1);
        chk("ready_in_frame", o_ready, 0);
        chk("done", o_done, (c == len));
        i_data            = 8'($urandom);
        i_bitnum          = 4'($urandom);
        i_exist_oddcheck  = 1'($urandom);
        i_exist_evencheck = 1'($urandom);
        i_exist_stop      = 1'($urandom);
        i_data_valid      = hold ? 1'b1 : 1'($urandom);
      end else begin
        chk("idle_tx", o_tx, 1);
        chk("idle_busy", o_busy, 0);
        chk("idle_ready", o_ready, 1);
        chk("idle_done", o_done, 0);
        i_data_valid = hold;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    #1;
    chk("rst_tx", o_tx, 1);
    chk("rst_ready", o_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);

    send(8'hA5, 4'd8, 0, 0, 0, 0, 0);
    send(8'h07, 4'd8, 1, 0, 1, 0, 0);
    send(8'h07, 4'd8, 0, 1, 1, 0, 0);
    send(8'h1F, 4'd5, 0, 1, 0, 0, 0);
    send(8'hD6, 4'd3, 0, 0, 1, 0, 0);
    send(8'hD6, 4'd12, 1, 0, 0, 0, 0);

    send(8'h3C, 4'd8, 1, 0, 1, 1, 0);
    send(8'hC3, 4'd6, 0, 1, 0, 1, 0);
    send(8'h5A, 4'd7, 0, 0, 1, 0, 0);

    send(8'h96, 4'd8, 0, 0, 1, 0, 70);
    send(8'h69, 4'd8, 0, 1, 1, 0, 0);

    for (int r = 0; r < 20; r++) begin
      send(8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           (r < 19) ? 1'($urandom) : 1'b0, 0);
    end

    for (int b = 0; b < 256; b++) begin
      send(8'(b), 4'd8, 1, 1, 1, 0, 0);
    end

    i_data_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter that generates the asynchronous frame consumed by the UART receive stage: idle-high line, start bit 0, 5–8 data bits LSB first, optional odd/even parity, optional stop bit.
- Runs on the same 16x oversampling clock as the receiver, so each bit lasts 16 clocks.
- Sits between a byte producer (valid/ready handshake) and the tx pin.
- Frame format is programmed per byte by the same configuration inputs the receiver uses.

Parameters:
- BIT_TICKS, 16: clocks per bit. Fixed by the x16 clock; must equal the receiver's oversampling ratio.
- GAP_BITS, 1: minimum idle-high bit-times forced after every frame, so the next start bit always produces a falling edge. Legal range 1–3.

Ports:
- i_clkx16, input, 1: 16x baud clock.
- i_rst, input, 1: synchronous, active-high reset.
- i_data, input, 8: byte to send. Bits above i_bitnum are ignored.
- i_data_valid, input, 1: producer has a byte.
- o_ready, output, 1: transmitter can accept a byte.
- i_exist_oddcheck, input, 1: append odd parity.
- i_exist_evencheck, input, 1: append even parity.
- i_exist_stop, input, 1: append one stop bit (1).
- i_bitnum, input, 4: data bit count, 5–8.
- o_tx, output, 1: serial line. Idle high.
- o_busy, output, 1: a frame or guard gap is in progress.
- o_done, output, 1: one-cycle pulse on the last clock of the guard gap.

Behaviour:
- Reset (synchronous, i_rst high at a clock edge): state=IDLE, o_tx=1, o_ready=1, o_busy=0, o_done=0; all counters cleared. Reset mid-frame aborts immediately; o_tx is 1 on the next clock.
- Handshake: a byte is accepted on a clock where i_data_valid & o_ready. o_ready = (state==IDLE) & ~i_rst. i_data_valid while o_ready=0 is ignored; no byte is queued.
- Acceptance latches i_data, the parity mode, stop enable and the clamped bit count. Config changes mid-frame have no effect.
- Bit count clamp: i_bitnum<5 → 5; i_bitnum>8 → 8.
- Parity mode: odd has priority if both parity flags are set.
  - Odd: parity bit = ~^(data masked to n bits), so the total count of ones is odd.
  - Even: parity bit = ^(masked data).
- All outputs are registered. Accept on edge N → o_tx=0 from edge N+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
  - IDLE → START on accept.
  - START → DATA after 16 clocks.
  - DATA holds bit k for 16 clocks, k=0..n-1, LSB first. Then → PARITY if parity is enabled, else STOP if stop is enabled, else GAP.
  - PARITY → STOP if stop is enabled, else GAP.
  - STOP → GAP.
  - GAP holds o_tx=1 for GAP_BITS*16 clocks, then → IDLE.
- o_tx value per state: START 0; DATA the data bit; PARITY the parity bit; STOP 1; GAP and IDLE 1.
- Counters:
  - 4-bit tick counter, 0..15, wraps at 15 and advances the bit.
  - 3-bit bit index.
  - 2-bit gap counter.
  - Tick counter reset to 0 on every state entry.
- Frame length in clocks = 16*(1+n+p+s+GAP_BITS), where p,s ∈ {0,1}.
- o_busy = 1 from edge N+1 until the clock after the final GAP clock.
- o_done pulses on the final GAP clock. o_ready rises on the following clock.
- Back-to-back traffic: with valid held high, the next accept occurs on the first IDLE clock. Minimum inter-frame idle = GAP_BITS*16 + 1 clocks.

Decomposition:
- Shared package uart_pkg:
  - state encoding: IDLE=0, START=1, RDATA/DATA=2, CHECK/PARITY=3, STOP=4, GAP=5, using the same numeric values as the receiver;
  - BIT_TICKS;
  - MIN_BITS=5, MAX_BITS=8;
  - parity-mode constants.
- Sub-module uart_bit_timer: tick counter with bit-end strobe; reused by the receiver for mid-bit sampling.
- Parity is computed inline.

Test Plan:
- 0xA5, 8 bits, no parity/stop → o_tx = 0,1,0,1,0,0,1,0,1 per 16-clock slot, then 16 clocks of 1; o_done at clock 160 after accept; o_ready high at 161.
- 0x07, 8 bits, odd parity, stop → parity slot 0, stop slot 1; frame 11 bits + gap = 192 clocks. Repeat with even parity → parity slot 1.
- 0x1F, i_bitnum=5, even parity → data slots 1,1,1,1,1, parity 1. Then i_bitnum=3 and i_bitnum=12 → frames of 5 and 8 data bits respectively.
- i_data_valid held high with 3 bytes, config toggled mid-frame → three frames with exact spacing; each uses its accept-time config; o_ready=0 throughout each frame.
- i_rst asserted in DATA slot 3 for 1 clock → o_tx=1, o_ready=1, o_busy=0 on the next clock; the next byte transmits cleanly.
- Loopback o_tx into the receive stage with both parity flags set → odd parity is used; every byte 0x00–0xFF is recovered.
